// File: rtl/uart_pkg.sv
// Constants and types shared by the UART receive, transmit and buffering blocks.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-file storage for the UART FIFO: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: captures receiver strobes, presents a first-word fall-through
// valid/ready stream, and tracks fill level, almost-full and dropped-byte status.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH        = UART_FIFO_DEPTH,
    parameter int unsigned DATA_W       = UART_DATA_W,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overrun,
    output logic [7:0]               drop_cnt,
    input  logic                     clr_overrun,
    input  logic                     flush
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_afull;
    logic          r_overrun;
    logic [7:0]    r_drop_cnt;

    logic          w_full;
    logic          w_rd_fire;
    logic          w_wr_fire;
    logic          w_drop;
    logic [LW-1:0] w_level_nxt;

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_rd_fire = (r_level != '0) && rd_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign w_wr_fire = wr_valid && (!w_full || w_rd_fire);
    assign w_drop    = wr_valid && w_full && !w_rd_fire;

    always_comb begin
        w_level_nxt = r_level;
        if (flush) begin
            w_level_nxt = '0;
        end else if (w_wr_fire && !w_rd_fire) begin
            w_level_nxt = r_level + 1'b1;
        end else if (w_rd_fire && !w_wr_fire) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_afull  <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_afull <= (w_level_nxt >= LW'(AFULL_THRESH));
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overrun  <= 1'b1;
            if (clr_overrun)               r_drop_cnt <= 8'd1;
            else if (r_drop_cnt != 8'hFF)  r_drop_cnt <= r_drop_cnt + 1'b1;
        end else if (clr_overrun) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_fire && !flush),
        .waddr (r_wr_ptr),
        .wdata (wr_data),
        .raddr (r_rd_ptr),
        .rdata (rd_data)
    );

    assign rd_valid    = (r_level != '0);
    assign level       = r_level;
    assign almost_full = r_afull;
    assign overrun     = r_overrun;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH 16, AFULL_THRESH 12).
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    uart_byte_t wr_data;
    logic       wr_valid;
    uart_byte_t rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] level;
    logic       almost_full;
    logic       overrun;
    logic [7:0] drop_cnt;
    logic       clr_overrun;
    logic       flush;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH        (16),
        .DATA_W       (8),
        .AFULL_THRESH (12)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .almost_full (almost_full),
        .overrun     (overrun),
        .drop_cnt    (drop_cnt),
        .clr_overrun (clr_overrun),
        .flush       (flush)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        clr_overrun = 1'b0; flush = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b exp 0", almost_full); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 8'h41 + 8'(i);
            tick();
            wr_valid = 1'b0;
            if (i == 0) begin
                n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h41) begin
                    n_err++; $display("FAIL basic_latency got v=%b d=%h exp v=1 d=41", rd_valid, rd_data); end
            end
            tick();
        end
        n_cmp++; if (level !== 5'd3) begin n_err++; $display("FAIL basic_level got %0d exp 3", level); end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h41 + 8'(i)) begin
                n_err++; $display("FAIL basic_read%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, 8'h41 + 8'(i)); end
            tick();
        end
        rd_ready = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0 || level !== 5'd0) begin
            n_err++; $display("FAIL basic_empty got v=%b lvl=%0d exp v=0 lvl=0", rd_valid, level); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_data = 8'(i);
            tick();
            n_cmp++; if (level !== 5'(i + 1) || almost_full !== (i + 1 >= 12)) begin
                n_err++; $display("FAIL fill_level%0d got lvl=%0d af=%b exp lvl=%0d af=%b",
                                  i, level, almost_full, i + 1, (i + 1 >= 12)); end
        end
        wr_data = 8'hFF;
        tick();
        wr_valid = 1'b0;
        n_cmp++; if (overrun !== 1'b1 || drop_cnt !== 8'd1 || level !== 5'd16) begin
            n_err++; $display("FAIL fill_drop got ovr=%b cnt=%0d lvl=%0d exp ovr=1 cnt=1 lvl=16", overrun, drop_cnt, level); end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                n_err++; $display("FAIL fill_read%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, 8'(i)); end
            tick();
        end
        rd_ready = 1'b0;
        n_cmp++; if (level !== 5'd0 || almost_full !== 1'b0) begin
            n_err++; $display("FAIL fill_drained got lvl=%0d af=%b exp lvl=0 af=0", level, almost_full); end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        n_cmp++; if (overrun !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++; $display("FAIL clr_overrun got ovr=%b cnt=%0d exp ovr=0 cnt=0", overrun, drop_cnt); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_data = 8'h10 + 8'(i);
            tick();
        end
        wr_data = 8'hAA; rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        n_cmp++; if (level !== 5'd16 || overrun !== 1'b0 || rd_data !== 8'h11) begin
            n_err++; $display("FAIL full_rw got lvl=%0d ovr=%b d=%h exp lvl=16 ovr=0 d=11", level, overrun, rd_data); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== ((i == 15) ? 8'hAA : 8'h11 + 8'(i))) begin
                n_err++; $display("FAIL full_rw_read%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data,
                                  (i == 15) ? 8'hAA : 8'h11 + 8'(i)); end
            tick();
        end
        rd_ready = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL full_rw_empty got v=%b exp 0", rd_valid); end
    endtask

    task automatic test_wrap();
        uart_byte_t q[$];
        int sent = 0;
        int rcvd = 0;
        logic w, r;
        for (int cyc = 0; cyc < 2000 && rcvd < 40; cyc++) begin
            w = (sent < 40) && (q.size() < 16) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            wr_valid = w; wr_data = 8'h80 + 8'(sent); rd_ready = r;
            n_cmp++; if (level !== 5'(q.size()) || rd_valid !== (q.size() != 0)) begin
                n_err++; $display("FAIL wrap_level cyc%0d got lvl=%0d v=%b exp lvl=%0d", cyc, level, rd_valid, q.size()); end
            if (r && q.size() != 0) begin
                n_cmp++; if (rd_data !== q[0]) begin
                    n_err++; $display("FAIL wrap_data%0d got %h exp %h", rcvd, rd_data, q[0]); end
            end
            tick();
            if (r && q.size() != 0) begin void'(q.pop_front()); rcvd++; end
            if (w) begin q.push_back(8'h80 + 8'(sent)); sent++; end
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
        n_cmp++; if (rcvd != 40) begin n_err++; $display("FAIL wrap_count got %0d exp 40", rcvd); end
    endtask

    task automatic test_saturate();
        wr_valid = 1'b1;
        for (int i = 0; i < 16 + 300; i++) begin
            wr_data = 8'(i);
            tick();
        end
        n_cmp++; if (drop_cnt !== 8'd255 || overrun !== 1'b1 || level !== 5'd16) begin
            n_err++; $display("FAIL sat_cnt got cnt=%0d ovr=%b lvl=%0d exp cnt=255 ovr=1 lvl=16", drop_cnt, overrun, level); end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0; wr_valid = 1'b0;
        n_cmp++; if (drop_cnt !== 8'd1 || overrun !== 1'b1) begin
            n_err++; $display("FAIL sat_clr_drop got cnt=%0d ovr=%b exp cnt=1 ovr=1", drop_cnt, overrun); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = 8'h30 + 8'(i);
            tick();
        end
        n_cmp++; if (level !== 5'd5) begin n_err++; $display("FAIL flush_pre got %0d exp 5", level); end
        flush = 1'b1; wr_data = 8'h55;
        tick();
        flush = 1'b0; wr_valid = 1'b0;
        n_cmp++; if (level !== 5'd0 || rd_valid !== 1'b0 || overrun !== 1'b1 || drop_cnt !== 8'd1) begin
            n_err++; $display("FAIL flush_state got lvl=%0d v=%b ovr=%b cnt=%0d exp lvl=0 v=0 ovr=1 cnt=1",
                              level, rd_valid, overrun, drop_cnt); end
        wr_valid = 1'b1; wr_data = 8'h66;
        tick();
        wr_valid = 1'b0;
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h66 || level !== 5'd1) begin
            n_err++; $display("FAIL flush_next got v=%b d=%h lvl=%0d exp v=1 d=66 lvl=1", rd_valid, rd_data, level); end
    endtask

    task automatic test_midreset();
        wr_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            wr_data = 8'hC0 + 8'(i);
            tick();
        end
        n_cmp++; if (almost_full !== 1'b1 || level !== 5'd14) begin
            n_err++; $display("FAIL midrst_pre got af=%b lvl=%0d exp af=1 lvl=14", almost_full, level); end
        rd_ready = 1'b1; reset_n = 1'b0;
        tick();
        reset_n = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
        n_cmp++; if (level !== 5'd0 || rd_valid !== 1'b0 || almost_full !== 1'b0 ||
                     overrun !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++; $display("FAIL midrst got lvl=%0d v=%b af=%b ovr=%b cnt=%0d exp all 0",
                              level, rd_valid, almost_full, overrun, drop_cnt); end
        tick();
        n_cmp++; if (level !== 5'd0 || rd_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_hold got lvl=%0d v=%b exp 0 0", level, rd_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overrun();
        test_full_rw();
        test_wrap();
        test_saturate();
        test_flush();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle data-ready pulse and stores it in a circular FIFO. Bytes are presented to the host/bus side on a valid/ready stream, along with fill level, almost-full, and overrun status. It decouples the bursty serial receive path from a host that cannot service every byte immediately.

Parameters:
DEPTH, 16, number of byte entries; power of 2, minimum 2.
DATA_W, 8, data width; matches the receiver byte width.
AFULL_THRESH, 12, almost_full asserts when level >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset_n  input  1  synchronous reset, active-low.
wr_data  input  DATA_W  byte from the receiver (its rx_data).
wr_valid  input  1  one-cycle write strobe (the receiver's rx_ready).
rd_data  output  DATA_W  head-of-FIFO byte.
rd_valid  output  1  FIFO non-empty; rd_data is valid.
rd_ready  input  1  consumer accepts the head when rd_valid && rd_ready.
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
almost_full  output  1  level >= AFULL_THRESH.
overrun  output  1  sticky flag: at least one byte was dropped.
drop_cnt  output  8  saturating count of dropped bytes.
clr_overrun  input  1  clears overrun and drop_cnt.
flush  input  1  empties the FIFO.

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - wr_ptr, rd_ptr and level go to 0.
  - rd_valid = 0, almost_full = 0, overrun = 0, drop_cnt = 0.
  - Storage contents are don't-care.
  - rd_data is don't-care while rd_valid = 0.
  - Reset mid-operation discards all stored bytes. There is no partial state.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - Full/empty is derived from the level register, not from pointer comparison.
- Write: accepted when wr_valid && (level < DEPTH || read-this-cycle).
  - The byte is stored at wr_ptr and wr_ptr increments.
- Read: occurs when rd_valid && rd_ready, and rd_ptr increments.
- Output timing:
  - rd_valid = (level != 0), driven from registered state.
  - rd_data = mem[rd_ptr]; first-word fall-through.
  - Latency: a byte written at edge N is visible on rd_data with rd_valid = 1 in the cycle after edge N.
- Level update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous write and read, or on neither.
- Full with simultaneous read:
  - The read frees the slot and the write is accepted.
  - level stays at DEPTH.
- Empty with wr_valid and rd_ready in the same cycle:
  - No read occurs, because rd_valid = 0.
  - The write is accepted and level goes to 1.
- Overrun: wr_valid while full with no read in the same cycle.
  - The byte is dropped; FIFO contents and pointers are unchanged.
  - overrun is set to 1.
  - drop_cnt increments, saturating at 255.
- clr_overrun:
  - Clears overrun and drop_cnt at the next edge.
  - If a drop occurs in the same cycle, the drop wins: overrun = 1, drop_cnt = 1.
- flush:
  - Sets wr_ptr = rd_ptr = 0 and level = 0 at the next edge.
  - It has priority over any write or read in the same cycle; both are discarded.
  - It does not affect overrun or drop_cnt.
- almost_full is registered from the next-level value, so it is coincident with level.
- No combinational path from wr_valid to any output.
- rd_valid, rd_data, level and almost_full do not depend combinationally on rd_ready.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_W = 8, shared with the receiver and transmitter.
  - Default FIFO depth constant UART_FIFO_DEPTH = 16.
  - Typedef uart_byte_t = logic [UART_DATA_W-1:0].
- Sub-module uart_fifo_mem: a register-file storage array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - Holds no control logic.
- Pointer, level and status logic stay in uart_rx_fifo.

Test Plan:
- Write 0x41, 0x42, 0x43 on three separate wr_valid pulses with rd_ready = 0:
  - level = 3 and rd_data = 0x41 one cycle after the first write.
  - Then hold rd_ready = 1: bytes read out in order 0x41, 0x42, 0x43, then rd_valid = 0 and level = 0.
- Fill with 16 bytes 0x00..0x0F:
  - almost_full asserts at level 12 and level reaches 16.
  - A 17th write of 0xFF is dropped: overrun = 1, drop_cnt = 1, and the readout is 0x00..0x0F.
- At full, pulse wr_valid = 0xAA together with rd_ready:
  - The head is consumed, 0xAA is accepted, level stays 16, overrun stays 0.
  - After draining, 0xAA is the last byte out.
- Wrap-around: run 40 write/read pairs of sequential bytes with random gaps:
  - Output order and values match the input exactly across multiple pointer wraps.
- Fill to 5, then pulse flush together with wr_valid = 0x55:
  - level = 0 and rd_valid = 0 the next cycle.
  - The next write of 0x66 comes out first.
  - overrun is unaffected.
- Produce 300 overruns while full:
  - drop_cnt saturates at 255.
  - clr_overrun in the same cycle as another drop gives overrun = 1 and drop_cnt = 1.
- reset_n = 0 for one edge mid-traffic:
  - All outputs take their reset values at that edge.
